ex_div: RTL and testbench

Iterative RV32M divider in the EX stage: executes DIV, DIVU, REM and REMU with a 32-iteration restoring algorithm. It is the producer of the divide stall request consumed by the pipeline control unit. While busy it requests a pipeline hold; on completion it presents the result and write-back address for one cycle.

---
 rtl/ex_div_pkg.sv | 30 +++
 rtl/ex_div_div_step.sv | 31 +++
 rtl/ex_div.sv | 178 +++++++++++++++++
 tb/tb_ex_div.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_RD_W   = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Signed variants need absolute values on entry and a sign fix on exit.
  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  // Remainder variants return the remainder instead of the quotient.
  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_div_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import ex_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] dvsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the extra top bit of diff is the borrow that decides restore vs keep.
  always_comb begin
    rem_sh = {rem_i, quot_i[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvsr_i};
    if (!diff[DATA_W]) begin
      rem_o  = diff[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage. Requests a
// pipeline stall while busy and presents the result for one cycle when done.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int RD_W   = DIV_RD_W
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [RD_W-1:0]   rd_addr_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              div_hold_o,
  output logic              done_o,
  output logic              wr_ena_o,
  output logic [DATA_W-1:0] result_o,
  output logic [RD_W-1:0]   rd_addr_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  div_op_e           op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic signed [DATA_W-1:0] dividend_s;
  logic signed [DATA_W-1:0] divisor_s;
  logic [DATA_W-1:0]        step_rem;
  logic [DATA_W-1:0]        step_quot;
  div_op_e                  op_in;
  logic                     in_signed;
  logic                     dividend_neg;
  logic                     divisor_neg;

  // Two's complement negation; MIN_VAL maps onto itself, which is exactly the
  // unsigned magnitude the iteration needs for -2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic is_neg);
    return is_neg ? neg2c(v) : v;
  endfunction

  // Quotient negated when operand signs differ; remainder follows the dividend.
  function automatic logic [DATA_W-1:0] sign_fix(input div_op_e op,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic nq,
                                                 input logic nr);
    if (op_is_rem(op)) return nr ? neg2c(r) : r;
    return nq ? neg2c(q) : q;
  endfunction

  assign op_in        = div_op_e'(op_i);
  assign in_signed    = op_is_signed(op_in);
  assign dividend_s   = $signed(dividend_i);
  assign divisor_s    = $signed(divisor_i);
  assign dividend_neg = in_signed && (dividend_s < $signed(DATA_W'(0)));
  assign divisor_neg  = in_signed && (divisor_s < $signed(DATA_W'(0)));

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  // Stall in the start cycle and throughout the iteration; a flush releases it.
  assign div_hold_o = ~flush_i &
                      (((state_q == DIV_IDLE) & start_i) | (state_q == DIV_CALC));
  assign done_o     = (state_q == DIV_DONE) & ~flush_i;
  assign wr_ena_o   = done_o;
  assign result_o   = result_q;
  assign rd_addr_o  = rd_q;

  // Next-state and datapath: flush beats hold, hold freezes everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else if (!hold_i) begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            op_d       = op_in;
            rd_d       = rd_addr_i;
            neg_quot_d = dividend_neg ^ divisor_neg;
            neg_rem_d  = dividend_neg;
            dvsr_d     = abs_val(divisor_i, divisor_neg);
            rem_d      = '0;
            quot_d     = abs_val(dividend_i, dividend_neg);
            cnt_d      = '0;
            if (divisor_i == '0) begin
              state_d  = DIV_DONE;
              result_d = op_is_rem(op_in) ? dividend_i : '1;
            end else if (in_signed && (dividend_i == MIN_VAL) && (divisor_i == '1)) begin
              state_d  = DIV_DONE;
              result_d = op_is_rem(op_in) ? '0 : MIN_VAL;
            end else begin
              state_d  = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = DIV_DONE;
            cnt_d    = '0;
            result_d = sign_fix(op_q, step_quot, step_rem, neg_quot_q, neg_rem_q);
          end
        end
        DIV_DONE: begin
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      op_q       <= DIV_OP_DIV;
      rd_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, corner cases,
// hold, flush and asynchronous reset behaviour.
module tb_ex_div;

  logic        clk_100MHz;
  logic        arst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        hold_i;
  logic        flush_i;
  logic        div_hold_o;
  logic        done_o;
  logic        wr_ena_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int errors = 0;
  int checks = 0;

  ex_div #(.DATA_W(32), .RD_W(5)) dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .div_hold_o (div_hold_o),
    .done_o     (done_o),
    .wr_ena_o   (wr_ena_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts an op at the current cycle (called just after a negedge) and keeps
  // start_i high through DONE. Returns at the start of the cycle after DONE.
  task automatic do_div(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input int done_cyc, input int hf, input int ht);
    int bad;
    bad = 0;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    for (int c = 0; c <= done_cyc; c++) begin
      hold_i = (c >= hf) && (c <= ht);
      #1;
      if (c < done_cyc) begin
        if (div_hold_o !== 1'b1 || done_o !== 1'b0) bad++;
      end else begin
        chk({tag, "_done"},   {31'd0, done_o},    32'd1);
        chk({tag, "_wr"},     {31'd0, wr_ena_o},  32'd1);
        chk({tag, "_hold"},   {31'd0, div_hold_o}, 32'd0);
        chk({tag, "_result"}, result_o,           exp_res);
        chk({tag, "_rd"},     {27'd0, rd_addr_o}, {27'd0, rd});
      end
      @(negedge clk_100MHz);
    end
    hold_i = 1'b0;
    chk({tag, "_busy"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int pulses;
    arst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    rd_addr_i = '0; hold_i = 1'b0; flush_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_100MHz);
    #1;
    chk("rst_done",   {31'd0, done_o},     32'd0);
    chk("rst_wr",     {31'd0, wr_ena_o},   32'd0);
    chk("rst_hold",   {31'd0, div_hold_o}, 32'd0);
    chk("rst_result", result_o,            32'd0);
    chk("rst_rd",     {27'd0, rd_addr_o},  32'd0);
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    @(negedge clk_100MHz);

    // Basic unsigned op, then drop start: no retrigger
    do_div("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33, -1, -1);
    start_i = 1'b0;
    #1;
    chk("retrig_done", {31'd0, done_o},     32'd0);
    chk("retrig_hold", {31'd0, div_hold_o}, 32'd0);
    @(negedge clk_100MHz);

    // Back-to-back ops, no idle cycle between them
    do_div("remu_100_7",   2'b11, 32'd100,        32'd7,          5'd6,  32'd2,          33, -1, -1);
    do_div("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33, -1, -1);
    do_div("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  33, -1, -1);
    do_div("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  33, -1, -1);
    do_div("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          33, -1, -1);
    do_div("div_5_0",      2'b00, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1,  -1, -1);
    do_div("rem_5_0",      2'b10, 32'd5,          32'd0,          5'd12, 32'd5,          1,  -1, -1);
    do_div("divu_5_0",     2'b01, 32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1,  -1, -1);
    do_div("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  1,  -1, -1);
    do_div("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          1,  -1, -1);
    do_div("divu_min_max", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          33, -1, -1);
    do_div("remu_min_max", 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  33, -1, -1);
    do_div("div_min_2",    2'b00, 32'h8000_0000,  32'd2,          5'd18, 32'hC000_0000,  33, -1, -1);
    start_i = 1'b0;
    @(negedge clk_100MHz);

    // Hold during CALC stretches latency by the held cycles
    do_div("divu_hold", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd19, 32'hFFFF_FFFF, 38, 5, 9);
    start_i = 1'b0;
    @(negedge clk_100MHz);

    // Hold during DONE keeps done_o high for an extra cycle
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd5; divisor_i = 32'd0; rd_addr_i = 5'd20;
    #1;
    chk("dhold_c0_hold", {31'd0, div_hold_o}, 32'd1);
    @(negedge clk_100MHz);
    hold_i = 1'b1;
    #1;
    chk("dhold_c1_done", {31'd0, done_o}, 32'd1);
    chk("dhold_c1_res",  result_o,        32'hFFFF_FFFF);
    @(negedge clk_100MHz);
    hold_i = 1'b0;
    #1;
    chk("dhold_c2_done", {31'd0, done_o}, 32'd1);
    @(negedge clk_100MHz);
    start_i = 1'b0;
    #1;
    chk("dhold_c3_done", {31'd0, done_o}, 32'd0);
    @(negedge clk_100MHz);

    // Flush coinciding with DONE suppresses the write-back
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd5; divisor_i = 32'd0; rd_addr_i = 5'd21;
    @(negedge clk_100MHz);
    flush_i = 1'b1;
    #1;
    chk("fdone_done", {31'd0, done_o},   32'd0);
    chk("fdone_wr",   {31'd0, wr_ena_o}, 32'd0);
    @(negedge clk_100MHz);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    chk("fdone_after", {31'd0, done_o}, 32'd0);
    @(negedge clk_100MHz);

    // Flush mid-iteration at cycle 10, restart at cycle 12
    pulses = 0;
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd22;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done_o) pulses++;
      @(negedge clk_100MHz);
    end
    flush_i = 1'b1;
    #1;
    chk("flush_c10_hold", {31'd0, div_hold_o}, 32'd0);
    if (done_o) pulses++;
    @(negedge clk_100MHz);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    chk("flush_c11_hold", {31'd0, div_hold_o}, 32'd0);
    if (done_o) pulses++;
    chk("flush_no_done", 32'(pulses), 32'd0);
    @(negedge clk_100MHz);
    do_div("after_flush", 2'b01, 32'd1000, 32'd10, 5'd3, 32'd100, 33, -1, -1);
    start_i = 1'b0;
    @(negedge clk_100MHz);

    // Asynchronous reset mid-operation
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd23;
    repeat (20) @(negedge clk_100MHz);
    arst_n = 1'b0; start_i = 1'b0;
    #1;
    chk("arst_done",   {31'd0, done_o},     32'd0);
    chk("arst_wr",     {31'd0, wr_ena_o},   32'd0);
    chk("arst_hold",   {31'd0, div_hold_o}, 32'd0);
    chk("arst_result", result_o,            32'd0);
    chk("arst_rd",     {27'd0, rd_addr_o},  32'd0);
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done_o || div_hold_o) pulses++;
      @(negedge clk_100MHz);
    end
    chk("arst_idle", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
